ws2812_pixel_out: RTL
=====================

WS2812_PIXEL_OUT -- requirements
Module: ws2812_pixel_out

Interface
REQ-001 Parameter PIXEL_BITS, default 24, bits per pixel word (24 RGB, 32 RGBW), legal 8..32.
REQ-002 Parameter CNT_W, default 8, width of per-phase timing counts.
REQ-003 Parameter GAP_W, default 16, width of latch-gap count.
REQ-004 clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 pix_valid_in  input  1  pixel word offered.
REQ-007 pix_data_in  input  PIXEL_BITS  pixel word, transmitted MSB first.
REQ-008 pix_ready_out  output  1  block accepts a pixel this cycle.
REQ-009 t0h_cnt_in / t0l_cnt_in / t1h_cnt_in / t1l_cnt_in  input  CNT_W each  high/low phase lengths in clk_in cycles for 0-bits and 1-bits.
REQ-010 gap_cnt_in  input  GAP_W  latch-gap length in cycles (present only with WS2812_LATCH_GAP_EN).
REQ-011 busy_out  output  1  high in any state other than IDLE.
REQ-012 pix_done_out  output  1  one-cycle pulse when the last bit of a pixel completes.
REQ-013 ws2812_data_out  output  1  registered serial line.

Function
REQ-014 FSM states IDLE, HIGH, LOW, GAP; GAP is reachable only with WS2812_LATCH_GAP_EN.
REQ-015 pix_ready_out = 1 in IDLE and in the final cycle of the LOW phase of the last bit; 0 otherwise.
REQ-016 Handshake = pix_valid_in & pix_ready_out; on handshake the word loads a shift register, bit index = PIXEL_BITS-1, FSM -> HIGH.
REQ-017 At each bit start the current bit selects (t1h,t1l) or (t0h,t0l), and both values are latched; input changes mid-bit have no effect on that bit.
REQ-018 Phase count 0 is treated as 1; phase lengths are thigh..and tlow cycles exactly, no extra cycles between phases or bits.
REQ-019 Handshake in cycle k: ws2812_data_out = 1 in cycles k+1..k+thigh, 0 in the following tlow cycles; the next bit starts immediately afterwards.
REQ-020 After the last bit's LOW phase: pix_done_out pulses in that final LOW cycle; a handshake in the same cycle chains the next pixel with zero idle cycles.
REQ-021 No handshake at the last-bit boundary: FSM -> GAP (macro on) or IDLE (macro off).
REQ-022 ws2812_data_out = 0 in IDLE, LOW and GAP.
REQ-023 pix_valid_in while pix_ready_out = 0 is ignored; no data is lost and no buffering is done beyond the shift register.

Reset
REQ-024 rst_in asserted: FSM = IDLE, shift register = 0, counters = 0, ws2812_data_out = 0, pix_done_out = 0, busy_out = 0 immediately (asynchronously), including mid-bit.
REQ-025 pix_ready_out = 1 in the first cycle after rst_in is deasserted.

Configuration
REQ-026 Macro WS2812_LATCH_GAP_EN defined: GAP state holds the line low for gap_cnt_in cycles (0 treated as 1), pix_ready_out = 0 and busy_out = 1 throughout, then IDLE.
REQ-027 Macro WS2812_LATCH_GAP_EN undefined: no GAP state, no gap_cnt_in port, and the line latch is the host's responsibility.

Structure
REQ-028 A shared package ws2812_pkg holds the FSM state enum and timing-select constants.
REQ-029 Sub-module ws2812_phase_cnt (loadable down-counter with a zero-to-one clamp and terminal pulse) serves HIGH, LOW and GAP timing.

Verification
REQ-030 PIXEL_BITS=24, t0h=3,t0l=7,t1h=7,t1l=3, word 0xA50000: line shows 1,0,1,0,0,1,0,1 then sixteen 0-bits; each bit is 10 cycles; pix_done_out rises at cycle 240 after handshake.
REQ-031 Two words held valid back-to-back: the second HIGH phase starts the cycle after the first word's last LOW cycle with zero gap; exactly two pix_done_out pulses.
REQ-032 Macro on, gap_cnt_in=50, single word: busy_out stays high 50 cycles after the last bit, pix_ready_out = 0 throughout, then IDLE.
REQ-033 t1h changed from 7 to 2 mid-bit: the current bit keeps 7 high cycles and the next 1-bit uses 2.
REQ-034 rst_in asserted at bit 5 HIGH: line drops to 0 asynchronously; after release, a new word transmits correctly from its MSB.
REQ-035 PIXEL_BITS=32, t0h=0, word 0: every bit has 1 high cycle (zero-clamp), 32 bits, then pix_done_out.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Purpose: shared types and constants for the WS2812 pixel serialiser.
// Latency: n/a (package only).
// Backpressure: n/a. Holds the FSM state enum, timing-select constants and a width helper.
package ws2812_pkg;

    // GAP is only entered when WS2812_LATCH_GAP_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ws_state_e;

    // Value of the current data bit that selects the 0-bit or 1-bit timing pair.
    localparam logic SEL_T0 = 1'b0;
    localparam logic SEL_T1 = 1'b1;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_pixel_out_if.sv
// Purpose: valid/ready pixel-word stream into the WS2812 serialiser.
// Latency: n/a (wires only).
// Backpressure: pix_ready_out from the slave; a word moves when valid & ready.
// Ports: pix_valid_in, pix_data_in[PIXEL_BITS] (master -> slave), pix_ready_out (slave -> master).
interface ws2812_pixel_out_if #(
    parameter int PIXEL_BITS = 24
);
    logic                  pix_valid_in;
    logic [PIXEL_BITS-1:0] pix_data_in;
    logic                  pix_ready_out;

    modport master (
        output pix_valid_in,
        output pix_data_in,
        input  pix_ready_out
    );

    modport slave (
        input  pix_valid_in,
        input  pix_data_in,
        output pix_ready_out
    );
endinterface

// File: rtl/ws2812_phase_cnt.sv
// Purpose: loadable down-counter timing one HIGH, LOW or GAP phase; a load of 0 counts as 1.
// Latency: tc_out is high in the last cycle of an N-cycle phase loaded in the previous cycle.
// Backpressure: none; reload in the tc_out cycle chains phases back-to-back.
// Ports: clk_in, rst_in (async active-high), load_in, load_val_in[W], tc_out.
module ws2812_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load_in,
    input  logic [W-1:0] load_val_in,
    output logic         tc_out
);

    logic [W-1:0] cnt_q;

    // The counter holds the number of cycles left in the phase including the current one,
    // so it reads 1 in the phase's final cycle and parks at 0 when nothing is running.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else if (load_in) begin
            cnt_q <= (load_val_in == '0) ? W'(1) : load_val_in;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_out = (cnt_q == W'(1));

endmodule

// File: rtl/ws2812_pixel_out.sv
// Purpose: serialise pixel words MSB first onto a WS2812 line with programmable per-bit timing.
// Latency: line goes high the cycle after the handshake; pix_done_out in the last LOW cycle.
// Backpressure: pix_ready_out only in IDLE or the last LOW cycle of a pixel, so words chain gap-free.
// Ports: clk_in, rst_in (async active-high), pix_if (slave), t0h/t0l/t1h/t1l_cnt_in[CNT_W],
//        gap_cnt_in[GAP_W] (only with WS2812_LATCH_GAP_EN), busy_out, pix_done_out, ws2812_data_out.
// Build option: define WS2812_LATCH_GAP_EN to hold the line low for a latch gap after each
//        unchained pixel; without it the block returns straight to IDLE.
module ws2812_pixel_out
    import ws2812_pkg::*;
#(
    parameter int PIXEL_BITS = 24,
    parameter int CNT_W      = 8,
    parameter int GAP_W      = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    ws2812_pixel_out_if.slave  pix_if,
    input  logic [CNT_W-1:0]   t0h_cnt_in,
    input  logic [CNT_W-1:0]   t0l_cnt_in,
    input  logic [CNT_W-1:0]   t1h_cnt_in,
    input  logic [CNT_W-1:0]   t1l_cnt_in,
`ifdef WS2812_LATCH_GAP_EN
    input  logic [GAP_W-1:0]   gap_cnt_in,
`endif
    output logic               busy_out,
    output logic               pix_done_out,
    output logic               ws2812_data_out
);

`ifdef WS2812_LATCH_GAP_EN
    localparam int PC_W = max_w(CNT_W, GAP_W);
`else
    localparam int PC_W = CNT_W;
`endif
    localparam int IDX_W = $clog2(PIXEL_BITS);

    ws_state_e             state_q, state_d;
    logic [PIXEL_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]      tlow_q, tlow_d;
    logic                  data_q, data_d;

    logic                  cnt_load;
    logic [PC_W-1:0]       cnt_val;
    logic                  cnt_tc;
    logic                  ready;
    logic                  done;
    logic                  start_bit;
    logic                  bit_sel;

    ws2812_phase_cnt #(.W(PC_W)) u_phase_cnt (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (cnt_load),
        .load_val_in (cnt_val),
        .tc_out      (cnt_tc)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tlow_q    <= '0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tlow_q    <= tlow_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tlow_d    = tlow_q;
        data_d    = data_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        ready     = 1'b0;
        done      = 1'b0;
        start_bit = 1'b0;
        bit_sel   = SEL_T0;

        case (state_q)
            ST_IDLE: begin
                ready  = 1'b1;
                data_d = 1'b0;
            end
            ST_HIGH: begin
                if (cnt_tc) begin
                    state_d  = ST_LOW;
                    data_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = PC_W'(tlow_q);
                end
            end
            ST_LOW: begin
                if (cnt_tc) begin
                    if (bit_idx_q != '0) begin
                        // The bit currently on the line sits at the MSB, so the next one
                        // is the bit just below it.
                        start_bit = 1'b1;
                        bit_sel   = shift_q[PIXEL_BITS-2];
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end else begin
                        ready = 1'b1;
                        done  = 1'b1;
`ifdef WS2812_LATCH_GAP_EN
                        state_d  = ST_GAP;
                        data_d   = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = PC_W'(gap_cnt_in);
`else
                        state_d  = ST_IDLE;
`endif
                    end
                end
            end
`ifdef WS2812_LATCH_GAP_EN
            ST_GAP: begin
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A handshake overrides the GAP/IDLE fall-back chosen above, which is what lets a
        // word offered in the last LOW cycle follow with no idle cycle.
        if (pix_if.pix_valid_in && ready) begin
            start_bit = 1'b1;
            bit_sel   = pix_if.pix_data_in[PIXEL_BITS-1];
            shift_d   = pix_if.pix_data_in;
            bit_idx_d = IDX_W'(PIXEL_BITS - 1);
        end

        // Both phase lengths are captured here so timing inputs moving mid-bit are ignored.
        if (start_bit) begin
            state_d  = ST_HIGH;
            data_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = (bit_sel == SEL_T1) ? PC_W'(t1h_cnt_in) : PC_W'(t0h_cnt_in);
            tlow_d   = (bit_sel == SEL_T1) ? t1l_cnt_in : t0l_cnt_in;
        end
    end

    assign pix_if.pix_ready_out = ready;
    assign pix_done_out         = done;
    assign busy_out             = (state_q != ST_IDLE);
    assign ws2812_data_out      = data_q;

endmodule
